// File: rtl/fir_bank_engine_if.sv
// Sample, coefficient-load and result signals of fir_bank_engine.
// The engine side takes the slave modport; the producer/consumer side takes master.
interface fir_bank_engine_if #(
  parameter int NTAPS = 211,
  parameter int DW    = 16,
  parameter int CW    = 32,
  parameter int NFILT = 4,
  parameter int NCH   = 2
);
  localparam int TAW = $clog2(NTAPS);
  localparam int FAW = (NFILT > 1) ? $clog2(NFILT) : 1;

  logic               in_valid;
  logic               in_ready;
  logic [NCH*DW-1:0]  in_data;
  logic [FAW-1:0]     filt_sel;
  logic               bypass;
  logic               coef_we;
  logic               coef_ready;
  logic [FAW+TAW-1:0] coef_addr;
  logic [CW-1:0]      coef_wdata;
  logic               out_valid;
  logic [NCH*DW-1:0]  out_data;
  logic [NCH-1:0]     out_sat;
  logic               overrun;

  modport master (
    output in_valid, in_data, filt_sel, bypass, coef_we, coef_addr, coef_wdata,
    input  in_ready, coef_ready, out_valid, out_data, out_sat, overrun
  );

  modport slave (
    input  in_valid, in_data, filt_sel, bypass, coef_we, coef_addr, coef_wdata,
    output in_ready, coef_ready, out_valid, out_data, out_sat, overrun
  );
endinterface

// File: rtl/fir_bank_engine.sv
// Multi-channel FIR engine: one sequential MAC shared by NCH channels, per-channel
// history ring buffers and NFILT run-time loadable coefficient banks with bypass.
module fir_bank_engine #(
  parameter int NTAPS = 211,
  parameter int DW    = 16,
  parameter int CW    = 32,
  parameter int CFRAC = 16,
  parameter int NFILT = 4,
  parameter int NCH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  fir_bank_engine_if.slave  io_bus
);
  localparam int TAW   = $clog2(NTAPS);
  localparam int FAW   = (NFILT > 1) ? $clog2(NFILT) : 1;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW    = DW + CW;
  localparam int ACC_W = DW + CW + TAW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [TAW-1:0] LAST_TAP = TAW'(NTAPS - 1);
  localparam logic [TAW:0]   NTAPS_F  = (TAW+1)'(NTAPS);
  localparam logic [FAW:0]   NFILT_F  = (FAW+1)'(NFILT);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NCH - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Returns {clipped, result}: floor of acc / 2^CFRAC, clipped to the DW range.
  function automatic logic [DW:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shr;
    shr = acc >>> CFRAC;
    if (shr > SAT_MAX)      round_sat = {1'b1, SAT_MAX[DW-1:0]};
    else if (shr < SAT_MIN) round_sat = {1'b1, SAT_MIN[DW-1:0]};
    else                    round_sat = {1'b0, shr[DW-1:0]};
  endfunction

  logic [DW-1:0] r_hist [NCH][NTAPS];
  logic [CW-1:0] r_coef [NFILT][NTAPS];

  logic [2:0]        r_state;
  logic [TAW-1:0]    r_wp;
  logic [TAW:0]      r_fill;
  logic [CHW-1:0]    r_ch;
  logic [TAW-1:0]    r_tap;
  logic [TAW-1:0]    r_ridx;
  logic              r_drain;
  logic [FAW-1:0]    r_sel;
  logic              r_byp;
  logic [NCH*DW-1:0] r_smp;
  logic              r_out_valid;
  logic [NCH*DW-1:0] r_out_data;
  logic [NCH-1:0]    r_out_sat;
  logic              r_overrun;
  logic [NCH*DW-1:0] r_res;
  logic [NCH-1:0]    r_rsat;

  logic                    r_vld_p1;
  logic                    r_vld_p2;
  logic signed [DW-1:0]    r_hdat_p1;
  logic signed [CW-1:0]    r_cdat_p1;
  logic signed [PW-1:0]    r_prod_p2;
  logic signed [ACC_W-1:0] r_acc;

  logic                    w_idle;
  logic                    w_accept;
  logic                    w_sel_bad;
  logic [FAW-1:0]          w_cbank;
  logic [TAW-1:0]          w_ctap;
  logic                    w_cwr;
  logic                    w_finish;
  logic signed [ACC_W-1:0] w_acc_fin;
  logic [DW:0]             w_rs;
  logic [NCH*DW-1:0]       w_res_vec;
  logic [NCH-1:0]          w_sat_vec;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = io_bus.in_valid & w_idle;
  assign w_sel_bad = ({1'b0, io_bus.filt_sel} >= NFILT_F);
  assign w_cbank   = io_bus.coef_addr[FAW+TAW-1:TAW];
  assign w_ctap    = io_bus.coef_addr[TAW-1:0];
  assign w_cwr     = io_bus.coef_we & w_idle &
                     ({1'b0, w_cbank} < NFILT_F) & ({1'b0, w_ctap} < NTAPS_F);
  assign w_finish  = (r_state == S_DRAIN) & r_drain;
  assign w_acc_fin = r_acc + (r_vld_p2 ? ACC_W'(r_prod_p2) : '0);
  assign w_rs      = round_sat(w_acc_fin);

  // Channels finish in order ch0..ch(NCH-1), so results shift in from the top.
  if (NCH > 1) begin : g_multi
    assign w_res_vec = {w_rs[DW-1:0], r_res[NCH*DW-1:DW]};
    assign w_sat_vec = {w_rs[DW], r_rsat[NCH-1:1]};
  end else begin : g_single
    assign w_res_vec = w_rs[DW-1:0];
    assign w_sat_vec = w_rs[DW];
  end

  assign io_bus.in_ready   = w_idle;
  assign io_bus.coef_ready = w_idle;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_data   = r_out_data;
  assign io_bus.out_sat    = r_out_sat;
  assign io_bus.overrun    = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wp        <= '0;
      r_fill      <= '0;
      r_ch        <= '0;
      r_tap       <= '0;
      r_ridx      <= '0;
      r_drain     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
      r_overrun   <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
    end else begin
      r_overrun   <= io_bus.in_valid & ~w_idle;
      r_vld_p1    <= (r_state == S_MAC) && ({1'b0, r_tap} < r_fill);
      r_vld_p2    <= r_vld_p1;
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_fill  <= (r_fill == NTAPS_F) ? r_fill : r_fill + 1'b1;
          r_ch    <= '0;
          r_tap   <= '0;
          r_ridx  <= r_wp;
          r_drain <= 1'b0;
          if (r_byp) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= r_smp;
            r_out_sat   <= '0;
          end else begin
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_tap  <= (r_tap == LAST_TAP) ? '0 : r_tap + 1'b1;
          r_ridx <= (r_ridx == '0) ? LAST_TAP : r_ridx - 1'b1;
          if (r_tap == LAST_TAP) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_drain <= ~r_drain;
          if (r_drain) begin
            if (r_ch == LAST_CH) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= w_res_vec;
              r_out_sat   <= w_sat_vec;
            end else begin
              r_state <= S_MAC;
              r_ch    <= r_ch + 1'b1;
              r_tap   <= '0;
              r_ridx  <= r_wp;
            end
          end
        end
        S_OUT: begin
          r_wp    <= (r_wp == LAST_TAP) ? '0 : r_wp + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_smp <= io_bus.in_data;
      r_sel <= io_bus.filt_sel;
      r_byp <= io_bus.bypass | w_sel_bad;
    end
    if (w_cwr) r_coef[w_cbank][w_ctap] <= io_bus.coef_wdata;
    if (r_state == S_WRITE) begin
      for (int c = 0; c < NCH; c++) r_hist[c][r_wp] <= r_smp[c*DW +: DW];
    end
    // p0 -> p1: history and coefficient reads for the tap issued this cycle
    r_hdat_p1 <= r_hist[r_ch][r_ridx];
    r_cdat_p1 <= r_coef[r_sel][r_tap];
    // p1 -> p2: full-precision product
    r_prod_p2 <= PW'(r_hdat_p1) * PW'(r_cdat_p1);
    // p2 -> accumulator; cleared at sample start and after each channel finalises
    if ((r_state == S_WRITE) || w_finish) r_acc <= '0;
    else if (r_vld_p2)                    r_acc <= r_acc + ACC_W'(r_prod_p2);
    if (w_finish) begin
      r_res  <= w_res_vec;
      r_rsat <= w_sat_vec;
    end
  end
endmodule

// File: tb/tb_fir_bank_engine.sv
// Directed bench for fir_bank_engine with NTAPS=8, NCH=2: impulse, fill/wrap,
// saturation, rounding, overrun/stall, bypass, bank switch and mid-MAC reset.
module tb_fir_bank_engine;
  localparam int NTAPS = 8;
  localparam int DW    = 16;
  localparam int CW    = 32;
  localparam int CFRAC = 16;
  localparam int NFILT = 4;
  localparam int NCH   = 2;
  localparam int FAW   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_bank_engine_if #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .NFILT(NFILT), .NCH(NCH)) bus ();

  fir_bank_engine #(
    .NTAPS(NTAPS), .DW(DW), .CW(CW), .CFRAC(CFRAC), .NFILT(NFILT), .NCH(NCH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk) begin
    if (bus.overrun)   ovr_cnt++;
    if (bus.out_valid) ov_cnt++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic coef_wr(input int bank, input int tap, input longint val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(bank * NTAPS + tap);
    bus.coef_wdata = CW'(val);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_out(output int g0, output int g1, output int sat, output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("out_timeout", 0, 1);
    g0  = int'($signed(bus.out_data[15:0]));
    g1  = int'($signed(bus.out_data[31:16]));
    sat = int'(bus.out_sat);
  endtask

  task automatic run(input int d0, input int d1, input int sel, input int sel_mid, input bit byp,
                     output int g0, output int g1, output int sat, output int lat);
    wait_ready();
    bus.in_data  = {16'(d1), 16'(d0)};
    bus.filt_sel = FAW'(sel);
    bus.bypass   = byp;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bypass   = 1'b0;
    bus.filt_sel = FAW'(sel_mid);
    wait_out(g0, g1, sat, lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, s, l, o0;
    int t2_in[12];
    int t2_ex[12];
    t2_in = '{100, 50, 25, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    t2_ex = '{100, 150, 175, 185, 195, 205, 215, 225, 135, 95, 80, 80};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.filt_sel = '0; bus.bypass = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    do_reset();

    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_out_data",   bus.out_data, 0);
    chk("rst_out_sat",    bus.out_sat, 0);
    chk("rst_overrun",    bus.overrun, 0);
    chk("rst_in_ready",   bus.in_ready, 1);
    chk("rst_coef_ready", bus.coef_ready, 1);

    for (int t = 0; t < NTAPS; t++) begin
      coef_wr(0, t, longint'(t + 1) << 16);
      coef_wr(1, t, 64'h10000);
      coef_wr(2, t, (t == 0) ? 64'h8000 : 64'h0);
    end

    // T1 impulse
    for (int n = 0; n < 10; n++) begin
      run((n == 0) ? 1 : 0, 0, 0, 0, 1'b0, g0, g1, s, l);
      chk($sformatf("t1_ch0_%0d", n), g0, (n < 8) ? n + 1 : 0);
      chk($sformatf("t1_ch1_%0d", n), g1, 0);
      chk($sformatf("t1_lat_%0d", n), l, 21);
    end

    // T2 fill and wrap, ch1 carries the negated stream
    do_reset();
    for (int n = 0; n < 12; n++) begin
      run(t2_in[n], -t2_in[n], 1, 1, 1'b0, g0, g1, s, l);
      chk($sformatf("t2_ch0_%0d", n), g0, t2_ex[n]);
      chk($sformatf("t2_ch1_%0d", n), g1, -t2_ex[n]);
    end

    // T3 saturation on both rails
    do_reset();
    for (int n = 0; n < 8; n++) begin
      run(32767, -32768, 1, 1, 1'b0, g0, g1, s, l);
      if (n == 0 || n == 7) begin
        chk($sformatf("t3_ch0_%0d", n), g0, 32767);
        chk($sformatf("t3_ch1_%0d", n), g1, -32768);
        chk($sformatf("t3_sat_%0d", n), s, (n == 0) ? 0 : 3);
      end
    end

    // floor rounding with a 0.5 coefficient
    do_reset();
    run(3, -3, 2, 2, 1'b0, g0, g1, s, l);
    chk("rnd_pos", g0, 1);
    chk("rnd_neg", g1, -2);
    chk("rnd_sat", s, 0);

    // T4 overrun and coefficient stall
    do_reset();
    run(1, 0, 0, 0, 1'b0, g0, g1, s, l);
    chk("t4_first", g0, 1);
    wait_ready();
    o0 = ovr_cnt;
    bus.in_data = '0; bus.filt_sel = '0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_data    = {16'd500, 16'd500};
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(1);
    bus.coef_wdata = CW'(99 << 16);
    chk("t4_coef_ready", bus.coef_ready, 0);
    chk("t4_in_ready", bus.in_ready, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.coef_we = 1'b0;
    wait_out(g0, g1, s, l);
    chk("t4_out", g0, 2);
    chk("t4_out_ch1", g1, 0);
    chk("t4_overruns", ovr_cnt - o0, 5);
    run(0, 0, 0, 0, 1'b0, g0, g1, s, l);
    chk("t4_next", g0, 3);

    // T5 bypass and bank switch during MAC
    do_reset();
    run(16'h1234, -5, 0, 0, 1'b1, g0, g1, s, l);
    chk("t5_byp_ch0", g0, 16'h1234);
    chk("t5_byp_ch1", g1, -5);
    chk("t5_byp_sat", s, 0);
    chk("t5_byp_lat", l, 1);
    do_reset();
    run(1, 0, 0, 0, 1'b0, g0, g1, s, l);
    chk("t5_imp", g0, 1);
    run(0, 0, 0, 1, 1'b0, g0, g1, s, l);
    chk("t5_sel_mid", g0, 2);

    // T6 reset at MAC tap 3
    do_reset();
    wait_ready();
    bus.in_data = {16'd0, 16'd1}; bus.filt_sel = '0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_in_ready", bus.in_ready, 1);
    o0 = ov_cnt;
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("t6_no_out", ov_cnt - o0, 0);
    run(1, 0, 0, 0, 1'b0, g0, g1, s, l);
    chk("t6_imp0", g0, 1);
    chk("t6_lat", l, 21);
    run(0, 0, 0, 0, 1'b0, g0, g1, s, l);
    chk("t6_imp1", g0, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
